// File: rtl/ref_row_fetcher_pkg.sv
// Shared constants, FSM state and return-tag types for the reference row fetcher.
package ref_row_fetcher_pkg;

  localparam int unsigned WIN       = 15;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned WORD_PIX  = 16;
  localparam int unsigned ROW_W     = WIN * PIX_W;
  localparam int unsigned WORD_W    = WORD_PIX * PIX_W;
  localparam int unsigned NUM_READS = 2 * WIN;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       is_b;
    logic [3:0] row;
  } tag_t;

  // Clamp a signed coordinate into [0, hi].
  function automatic logic [12:0] clamp_hi(input logic signed [13:0] v, input int hi);
    if (v < 14'sd0) return '0;
    if (int'(v) > hi) return 13'(hi);
    return v[12:0];
  endfunction

endpackage

// File: rtl/ref_row_fetcher_row_aligner.sv
// Selects 15 pixels out of the {B,A} word pair and registers the row with its load strobe.
module row_aligner
  import ref_row_fetcher_pkg::*;
(
  input  logic                clock,
  input  logic                reset_L,
  input  logic                i_valid,
  input  logic [2*WORD_W-1:0] i_pair,
  input  logic [3:0]          i_off,
  output logic [ROW_W-1:0]    o_row,
  output logic                o_load_L
);

  logic [2*WORD_W-1:0] w_shift;
  logic [ROW_W-1:0]    w_row;

  always_comb begin
    w_shift = i_pair >> {i_off, 3'b000};
    w_row   = w_shift[ROW_W-1:0];
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      o_row    <= '0;
      o_load_L <= 1'b1;
    end else begin
      o_load_L <= ~i_valid;
      if (i_valid) o_row <= w_row;
    end
  end

endmodule

// File: rtl/ref_row_fetcher.sv
// Fetches a 15x15 reference window from frame memory with edge replication and
// streams it row by row to the interpolation shift register.
module ref_row_fetcher
  import ref_row_fetcher_pkg::*;
#(
  parameter int unsigned PIC_W   = 1920,
  parameter int unsigned PIC_H   = 1080,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 18
) (
  input  logic                clock,
  input  logic                reset_L,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic signed [12:0]  req_x,
  input  logic signed [12:0]  req_y,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [127:0]        mem_rd_data,
  output logic [119:0]        row_out,
  output logic                load_L,
  output logic                done
);

  localparam int unsigned WORDS_PER_ROW = PIC_W / WORD_PIX;
  localparam int          XMAX          = int'(PIC_W) - int'(WIN);
  localparam int          YMAX          = int'(PIC_H) - 1;

  state_t             r_state;
  logic               r_ready;
  logic               r_rd_en;
  logic [ADDR_W-1:0]  r_addr;
  logic [12:0]        r_xc;
  logic signed [12:0] r_y0;
  logic [4:0]         r_k;
  tag_t               r_issue;
  tag_t               r_pipe [MEM_LAT];
  logic [WORD_W-1:0]  r_a;
  logic               r_done;

  logic [12:0]        w_xc;
  logic [3:0]         w_row;
  logic signed [13:0] w_ysum;
  logic [12:0]        w_yr;
  logic [ADDR_W-1:0]  w_word_a;
  logic [ADDR_W-1:0]  w_a1;
  logic [ADDR_W-1:0]  w_word_b;
  logic [ADDR_W-1:0]  w_addr;
  tag_t               w_ret;
  logic               w_ret_b;

  always_comb begin
    w_xc     = clamp_hi({req_x[12], req_x}, XMAX);
    w_row    = r_k[4:1];
    w_ysum   = $signed({r_y0[12], r_y0}) + $signed({10'd0, w_row});
    w_yr     = clamp_hi(w_ysum, YMAX);
    w_word_a = ADDR_W'(r_xc >> 4);
    w_a1     = w_word_a + ADDR_W'(1);
    // Rightmost window never needs a word past the picture edge.
    w_word_b = (w_a1 == ADDR_W'(WORDS_PER_ROW)) ? w_word_a : w_a1;
    w_addr   = ADDR_W'(w_yr) * ADDR_W'(WORDS_PER_ROW) + (r_k[0] ? w_word_b : w_word_a);
    w_ret    = r_pipe[MEM_LAT-1];
    w_ret_b  = w_ret.valid & w_ret.is_b;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_rd_en <= 1'b0;
      r_addr  <= '0;
      r_xc    <= '0;
      r_y0    <= '0;
      r_k     <= '0;
      r_issue <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rd_en <= 1'b0;
          r_issue <= '0;
          if (req_valid && r_ready) begin
            r_xc    <= w_xc;
            r_y0    <= req_y;
            r_k     <= '0;
            r_ready <= 1'b0;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          r_rd_en       <= 1'b1;
          r_addr        <= w_addr;
          r_issue.valid <= 1'b1;
          r_issue.is_b  <= r_k[0];
          r_issue.row   <= w_row;
          r_k           <= r_k + 5'd1;
          if (r_k == 5'(NUM_READS - 1)) r_state <= DRAIN;
        end
        DRAIN: begin
          r_rd_en <= 1'b0;
          r_issue <= '0;
          if (r_done) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_rd_en <= 1'b0;
          r_issue <= '0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Tag pipe tracks each read to its data return; clearing it drops in-flight data.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int unsigned i = 0; i < MEM_LAT; i++) r_pipe[i] <= '0;
      r_a    <= '0;
      r_done <= 1'b0;
    end else begin
      r_pipe[0] <= r_issue;
      for (int unsigned i = 1; i < MEM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      if (w_ret.valid && !w_ret.is_b) r_a <= mem_rd_data;
      r_done <= w_ret_b && (w_ret.row == 4'(WIN - 1));
    end
  end

  row_aligner u_row_aligner (
    .clock    (clock),
    .reset_L  (reset_L),
    .i_valid  (w_ret_b),
    .i_pair   ({mem_rd_data, r_a}),
    .i_off    (r_xc[3:0]),
    .o_row    (row_out),
    .o_load_L (load_L)
  );

  assign req_ready = r_ready;
  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_addr;
  assign done      = r_done;

endmodule

// File: tb/tb_ref_row_fetcher.sv
// Bench for ref_row_fetcher: memory model, row/address scoreboard, spot-value table and corner sequences.
module tb_ref_row_fetcher;
  import ref_row_fetcher_pkg::*;

  localparam int PW = 64;
  localparam int PH = 32;
  localparam int L  = 2;
  localparam int AW = 18;

  logic               clock = 1'b0;
  logic               reset_L = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic signed [12:0] req_x = '0;
  logic signed [12:0] req_y = '0;
  logic               mem_rd_en;
  logic [AW-1:0]      mem_addr;
  logic [127:0]       mem_rd_data;
  logic [119:0]       row_out;
  logic               load_L;
  logic               done;

  ref_row_fetcher #(.PIC_W(PW), .PIC_H(PH), .MEM_LAT(L), .ADDR_W(AW)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .row_out     (row_out),
    .load_L      (load_L),
    .done        (done)
  );

  always #5 clock = ~clock;

  typedef struct { logic [119:0] row; int cyc; int r; bit last; } row_exp_t;
  typedef struct { logic [AW-1:0] addr; int cyc; } addr_exp_t;
  typedef struct { int x; int y; int r1; int b1; logic [7:0] v1; int r2; int b2; logic [7:0] v2; } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accepts = 0;
  int last_e0 = 0;
  int done_cyc = -1;
  row_exp_t rq[$];
  addr_exp_t aq[$];
  logic [119:0] cap [15];
  logic [119:0] cap1 [15];
  logic [127:0] md [L];
  vec_t tbl [6];

  assign mem_rd_data = md[L-1];

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [7:0] pix(int x, int y);
    return 8'((x + 3*y) & 255);
  endfunction

  function automatic logic [127:0] mem_word(logic [AW-1:0] a);
    logic [127:0] w;
    int y;
    int xb;
    y  = int'(a) / (PW/16);
    xb = (int'(a) % (PW/16)) * 16;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = pix(xb + k, y);
    return w;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_expect(int x, int y);
    int xc;
    int a;
    int b;
    xc = clampi(x, 0, PW-15);
    a  = xc / 16;
    b  = (a + 1 == PW/16) ? a : a + 1;
    for (int r = 0; r < 15; r++) begin
      row_exp_t e;
      addr_exp_t ea;
      addr_exp_t eb;
      int yr;
      yr = clampi(y + r, 0, PH-1);
      for (int i = 0; i < 15; i++) e.row[i*8 +: 8] = pix(xc + i, yr);
      e.cyc  = cyc + 2*r + 3 + L;
      e.r    = r;
      e.last = (r == 14);
      rq.push_back(e);
      ea.addr = AW'(yr*(PW/16) + a);
      ea.cyc  = cyc + 1 + 2*r;
      eb.addr = AW'(yr*(PW/16) + b);
      eb.cyc  = cyc + 2 + 2*r;
      aq.push_back(ea);
      aq.push_back(eb);
    end
  endtask

  // Frame memory model and accept detection.
  always @(posedge clock) begin
    cyc++;
    md[0] <= mem_rd_en ? mem_word(mem_addr) : {16{8'hEE}};
    for (int i = 1; i < L; i++) md[i] <= md[i-1];
    if (reset_L && req_valid && req_ready) begin
      last_e0 = cyc;
      accepts++;
      push_expect(int'(req_x), int'(req_y));
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_L) begin
      if (mem_rd_en) begin
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got addr %0d expected no read (cycle %0d)", mem_addr, cyc);
        end else begin
          addr_exp_t ea;
          ea = aq.pop_front();
          chk("rd_addr", 128'(mem_addr), 128'(ea.addr));
          chk("rd_cycle", 128'(cyc), 128'(ea.cyc));
        end
      end
      if (!load_L) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL load_unexpected: got load_L=0 expected 1 (cycle %0d)", cyc);
        end else begin
          row_exp_t e;
          e = rq.pop_front();
          chk($sformatf("row%0d_data", e.r), 128'(row_out), 128'(e.row));
          chk($sformatf("row%0d_cycle", e.r), 128'(cyc), 128'(e.cyc));
          chk($sformatf("row%0d_done", e.r), 128'(done), 128'(e.last));
          cap[e.r] = row_out;
          if (e.last) done_cyc = cyc;
        end
      end else if (done) begin
        checks++; errors++;
        $display("FAIL done_stray: got done=1 expected 0 with load_L=1 (cycle %0d)", cyc);
      end
    end
  end

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_ready"}, 128'(req_ready), 128'(1));
    chk({tag, "_rd_en"}, 128'(mem_rd_en), 128'(0));
    chk({tag, "_addr"}, 128'(mem_addr), 128'(0));
    chk({tag, "_row"}, 128'(row_out), 128'(0));
    chk({tag, "_load_L"}, 128'(load_L), 128'(1));
    chk({tag, "_done"}, 128'(done), 128'(0));
  endtask

  task automatic do_req(int x, int y);
    int a0;
    a0 = accepts;
    req_x = 13'(x);
    req_y = 13'(y);
    req_valid = 1'b1;
    for (int t = 0; t < 100 && accepts == a0; t++) @(negedge clock);
    if (accepts == a0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected one for (%0d,%0d)", x, y);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int seen;
    seen = 0;
    for (int t = 0; t < 100 && seen == 0; t++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    if (seen == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected pulse (cycle %0d)", cyc);
    end
    @(negedge clock);
  endtask

  initial begin
    tbl[0] = '{16,  4, 0, 0, 8'h1C,  0, 14, 8'h2A};
    tbl[1] = '{21,  0, 0, 14, 8'h23, 14, 0, 8'h3F};
    tbl[2] = '{ 0, -3, 3, 0, 8'h00,  4, 0, 8'h03};
    tbl[3] = '{60, 10, 0, 0, 8'h4F,  0, 14, 8'h5D};
    tbl[4] = '{-5, 10, 0, 0, 8'h1E, 14, 14, 8'h56};
    tbl[5] = '{ 8, 25, 6, 0, 8'h65, 14, 0, 8'h65};

    repeat (3) @(negedge clock);
    chk_reset_outputs("por");
    reset_L = 1'b1;
    @(negedge clock);

    for (int t = 0; t < 6; t++) begin
      do_req(tbl[t].x, tbl[t].y);
      wait_done();
      chk($sformatf("v%0d_spot1", t), 128'(cap[tbl[t].r1][tbl[t].b1*8 +: 8]), 128'(tbl[t].v1));
      chk($sformatf("v%0d_spot2", t), 128'(cap[tbl[t].r2][tbl[t].b2*8 +: 8]), 128'(tbl[t].v2));
      if (t == 0) begin
        chk("s1_done_cycle", 128'(done_cyc - last_e0), 128'(31 + L));
        for (int r = 0; r < 15; r++) cap1[r] = cap[r];
      end
    end

    // Busy-ignore: request held high, fields disturbed while busy.
    begin
      int e0;
      int a0;
      a0 = accepts;
      req_x = 13'(8); req_y = 13'(25); req_valid = 1'b1;
      for (int t = 0; t < 20 && accepts == a0; t++) @(negedge clock);
      e0 = last_e0;
      repeat (5) @(negedge clock);
      req_x = 13'(40); req_y = 13'(0);
      repeat (5) @(negedge clock);
      req_x = 13'(8); req_y = 13'(25);
      for (int t = 0; t < 100 && accepts < a0 + 2; t++) @(negedge clock);
      req_valid = 1'b0;
      chk("busy_accepts", 128'(accepts - a0), 128'(2));
      chk("busy_second_accept", 128'(last_e0 - e0), 128'(33 + L));
      chk("busy_done_cycle", 128'(done_cyc - e0), 128'(31 + L));
      wait_done();
      for (int r = 6; r < 15; r++)
        chk($sformatf("bottom_row%0d", r), 128'(cap[r][7:0]), 128'(8'h65));
    end

    // Reset in the middle of a window.
    begin
      int e0;
      do_req(16, 4);
      e0 = last_e0;
      for (int t = 0; t < 50 && cyc < e0 + 10; t++) @(negedge clock);
      reset_L = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      rq.delete();
      aq.delete();
      for (int t = 0; t < 3; t++) begin
        @(negedge clock);
        chk("midrst_hold_load_L", 128'(load_L), 128'(1));
      end
      reset_L = 1'b1;
      repeat (8) @(negedge clock);
      chk("post_rst_queue", 128'(rq.size()), 128'(0));
      do_req(16, 4);
      wait_done();
      chk("post_rst_done_cycle", 128'(done_cyc - last_e0), 128'(31 + L));
      for (int r = 0; r < 15; r++)
        chk($sformatf("post_rst_row%0d", r), 128'(cap[r]), 128'(cap1[r]));
    end

    repeat (4) @(negedge clock);
    chk("final_rows_left", 128'(rq.size()), 128'(0));
    chk("final_reads_left", 128'(aq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/ref_row_fetcher.md
# ref_row_fetcher

Fetches the 15×15 integer-pixel reference window for one 8×8 interpolation block from frame memory. It streams the window to `input_shift_reg` one 15-pixel row at a time, using that block's active-low `load_L` strobe. Vertical and horizontal picture-edge handling is done here, so the filter datapath always sees a full window. It sits between the motion-compensation request source and `input_shift_reg`.

## Interface
Parameters:
- `PIC_W`, 1920: picture width in pixels; multiple of 16.
- `PIC_H`, 1080: picture height in pixels.
- `MEM_LAT`, 2: fixed frame-memory read latency in cycles; legal range 1..4.
- `ADDR_W`, 18: frame-memory word-address width.

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  window request.
- `req_ready`  out  1  high only in IDLE; accept when `req_valid & req_ready`.
- `req_x`  in  13  signed window left column x0.
- `req_y`  in  13  signed window top row y0.
- `mem_rd_en`  out  1  read strobe, one word per cycle.
- `mem_addr`  out  ADDR_W  word address = y*(PIC_W/16) + x/16.
- `mem_rd_data`  in  128  16 pixels; pixel k at [k*8+:8]; valid MEM_LAT cycles after the strobe.
- `row_out`  out  120  15 pixels; pixel i at [i*8+:8] = window column x0+i.
- `load_L`  out  1  active-low, one cycle per row; drives `input_shift_reg.load_L`.
- `done`  out  1  one-cycle pulse coincident with the row-14 `load_L`.

## Operation
- FSM states and transitions:
  - IDLE → FETCH on accept. Latch xc = clamp(req_x, 0, PIC_W-15) and y0.
  - FETCH issues 30 reads, then → DRAIN.
  - DRAIN → IDLE after row 14 is emitted.
- Row r (0..14):
  - Source row yr = clamp(y0+r, 0, PIC_H-1), which replicates edge rows.
  - Word A = xc>>4. Word B = A+1, clamped to A when A+1 == PIC_W/16.
  - Reads are issued A then B, consecutive cycles.
- Return path:
  - A MEM_LAT-deep tag pipe carries {valid, isB, row}.
  - A data is held in a 128-bit register.
  - On B return: row_out = bytes off..off+14 of {B,A}, with off = xc[3:0]. load_L is driven low for that cycle.
  - When off ≤ 1, B bytes are unused.
- `req_valid` is ignored outside IDLE. Request fields are sampled only at accept.
- Reset, including mid-operation:
  - Outputs go to reset values immediately: `req_ready`=1, `mem_rd_en`=0, `mem_addr`=0, `row_out`=0, `load_L`=1, `done`=0.
  - State → IDLE and the tag pipe is cleared.
  - Memory data returning after reset is ignored.

## Timing
- Accept at edge E0.
- Read k (k=0..29) is driven in cycle E0+1+k. Row r word A uses k=2r, word B uses k=2r+1.
- Row r is presented (`load_L`=0, `row_out` valid) in cycle E0+2r+3+MEM_LAT. Rows are therefore spaced 2 cycles apart with `load_L`=1 in between.
- `done` is high in cycle E0+31+MEM_LAT. IDLE (`req_ready`=1) follows in the next cycle.
- All outputs are registered. `load_L` changes on posedge and is stable across the `input_shift_reg` negedge capture.

## Structure
- Shared package holds:
  - constants WIN=15, PIX_W=8, WORD_PIX=16;
  - the FSM state enum {IDLE, FETCH, DRAIN};
  - the tag-pipe entry struct.
- Sub-module `row_aligner`:
  - Inputs: 256-bit {B,A} plus a 4-bit offset.
  - Function: extracts the 120-bit row and registers it together with `load_L`.
- Top level holds the FSM, clamp/address arithmetic, tag pipe and A-holding register.

## Test plan
Bench settings: PIC_W=64, PIC_H=32, MEM_LAT=2. Memory model returns pixel(x,y) = (x+3y)&0xFF.
- **Aligned interior.** Request (16,4).
  - 15 `load_L` pulses in cycles E0+5, E0+7, …, E0+33.
  - Row 0 byte0 = 0x1C, byte14 = 0x2A. `done` is high in cycle E0+33.
- **Straddle.** Request (21,0).
  - Row 0 addresses are 1 then 2.
  - Row 0 bytes = 0x15..0x23. Row 14 byte0 = 0x3F.
- **Top clamp.** Request (0,-3).
  - Rows 0..3 all equal picture row 0 (byte0 = 0x00).
  - Row 4 byte0 = 0x03.
- **Horizontal clamp.** Request (60,10), then (-5,10).
  - First request: xc=49, row 0 byte0 = 0x4F; word B address equals word A address.
  - Second request: xc=0, row 0 byte0 = 0x1E.
- **Bottom clamp and busy-ignore.** Request (8,25) with `req_valid` held high throughout.
  - Rows 6..14 identical (row 31, byte0 = 0x65).
  - Second accept occurs only in the cycle after `done`.
- **Reset mid-operation.** Drop `reset_L` at E0+10.
  - Outputs take reset values immediately.
  - No `load_L` pulse appears from in-flight returns.
  - After release, request (16,4) reproduces scenario 1 exactly.
